// File: rtl/ysyx_22050518_cmp_iter.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_cmp_iter
//
// Multi-cycle integer compare unit for the execute stage. It resolves
// BEQ/BNE/BLT/BGE/BLTU/BGEU and SLT/SLTU, including RV64 word mode.
// Operands are compared MSB-first, CHUNK bits per cycle, and the compare stops
// at the first chunk that differs. Only one request is in flight at a time.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous squash, discards any in-flight request
//   in_valid/ready  request handshake; op, word, src0, src1 are the request
//   out_valid/ready result handshake
//   out_res         {XLEN-1 zeros, result bit of the requested op}
//   out_lt/ltu/eq   signed less-than, unsigned less-than, equality flags
// ---------------------------------------------------------------------------
module ysyx_22050518_cmp_iter #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] src0,
    input  logic [XLEN-1:0] src1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_lt,
    output logic            out_ltu,
    output logic            out_eq
);

    localparam int NCH = XLEN / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [KW-1:0] K_FULL = KW'(NCH - 1);
    localparam logic [KW-1:0] K_WORD = KW'(32 / CHUNK - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_EQ  = 3'b000;
    localparam logic [2:0] OP_NE  = 3'b001;
    localparam logic [2:0] OP_LT  = 3'b010;
    localparam logic [2:0] OP_GE  = 3'b011;
    localparam logic [2:0] OP_LTU = 3'b100;
    localparam logic [2:0] OP_GEU = 3'b101;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [KW-1:0]   k_q, k_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            lt_q, lt_d;
    logic            ltu_q, ltu_d;
    logic            eq_q, eq_d;

    logic             accept;
    logic [CHUNK-1:0] a_ch, b_ch;
    logic             sa, sb;
    logic             ch_diff, ch_ltu, ch_lt;

    function automatic logic op_bit(input logic [2:0] o, input logic lt,
                                    input logic ltu, input logic eq);
        logic r;
        case (o)
            OP_EQ:   r = eq;
            OP_NE:   r = ~eq;
            OP_LT:   r = lt;
            OP_GE:   r = ~lt;
            OP_LTU:  r = ltu;
            OP_GEU:  r = ~ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        in_ready = ~flush & ((state_q == S_IDLE) |
                             ((state_q == S_DONE) & out_ready));
        accept   = in_valid & in_ready;
    end

    // Current chunk select; word mode only ever visits the low 32/CHUNK chunks.
    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (k_q == KW'(i)) begin
                a_ch = a_q[i*CHUNK +: CHUNK];
                b_ch = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        sa      = word_q ? a_q[31] : a_q[XLEN-1];
        sb      = word_q ? b_q[31] : b_q[XLEN-1];
        ch_diff = (a_ch != b_ch);
        ch_ltu  = (a_ch < b_ch);
        // First differing chunk decides; opposite signs decide by sign alone.
        ch_lt   = (sa ^ sb) ? sa : ch_ltu;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        word_d  = word_q;
        k_d     = k_q;
        res_d   = res_q;
        lt_d    = lt_q;
        ltu_d   = ltu_q;
        eq_d    = eq_q;

        case (state_q)
            S_BUSY: begin
                if (ch_diff) begin
                    lt_d    = ch_lt;
                    ltu_d   = ch_ltu;
                    eq_d    = 1'b0;
                    res_d   = '0;
                    res_d[0] = op_bit(op_q, ch_lt, ch_ltu, 1'b0);
                    state_d = S_DONE;
                end else if (k_q == '0) begin
                    lt_d    = 1'b0;
                    ltu_d   = 1'b0;
                    eq_d    = 1'b1;
                    res_d   = '0;
                    res_d[0] = op_bit(op_q, 1'b0, 1'b0, 1'b1);
                    state_d = S_DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept is possible from IDLE or from a completing DONE (no bubble).
        if (accept) begin
            a_d     = src0;
            b_d     = src1;
            op_d    = op;
            word_d  = word;
            k_d     = word ? K_WORD : K_FULL;
            state_d = S_BUSY;
        end

        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            word_q  <= word_d;
            k_q     <= k_d;
            res_q   <= res_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        out_valid = (state_q == S_DONE);
        out_res   = res_q;
        out_lt    = lt_q;
        out_ltu   = ltu_q;
        out_eq    = eq_q;
    end

endmodule
